// File: rtl/mod_arbiter.sv
// mod_arbiter: round-robin arbiter/sequencer sharing one combinational MOD unit
// among NUMREQ requesters.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        synchronous active-low reset
//   req_valid  per-requester operand-pair valid
//   req_ready  per-requester accept strobe (one-hot or zero, combinational in IDLE)
//   req_a      packed dividends, requester i at [i*DATAWIDTH +: DATAWIDTH]
//   req_b      packed divisors, same packing
//   rsp_valid  per-requester response valid (one-hot or zero)
//   rsp_ready  per-requester response consume
//   rsp_rem    remainder (divisor-zero returns the dividend)
//   rsp_dz     divisor was zero
//   busy       transaction outstanding (EXEC or RESP)

// Shared combinational MOD datapath with divide-by-zero protection.
module mod_unit #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] rem,
   output logic         dz
);
   assign dz  = (b == '0);
   assign rem = dz ? a : a % b;
endmodule

module mod_arbiter #(
   parameter int DATAWIDTH = 32,
   parameter int NUMREQ    = 4
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic [NUMREQ-1:0]           req_valid,
   output logic [NUMREQ-1:0]           req_ready,
   input  logic [NUMREQ*DATAWIDTH-1:0] req_a,
   input  logic [NUMREQ*DATAWIDTH-1:0] req_b,
   output logic [NUMREQ-1:0]           rsp_valid,
   input  logic [NUMREQ-1:0]           rsp_ready,
   output logic [DATAWIDTH-1:0]        rsp_rem,
   output logic                        rsp_dz,
   output logic                        busy
);
   localparam int IW = $clog2(NUMREQ);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                           state;
   logic [DATAWIDTH-1:0]             op_a, op_b;
   logic [DATAWIDTH-1:0]             mod_rem;
   logic                             mod_dz;
   logic [NUMREQ-1:0]                gnt;
   logic [IW-1:0]                    last;
   logic [IW-1:0]                    win, cand;
   logic                             win_found;
   logic [NUMREQ-1:0][DATAWIDTH-1:0] a_arr, b_arr;

   assign a_arr = req_a;
   assign b_arr = req_b;

   // Search from last+1 upward with wrap; the explicit wrap keeps this
   // correct for non-power-of-two NUMREQ.
   always_comb begin
      win       = last;
      win_found = 1'b0;
      cand      = last;
      for (int k = 0; k < NUMREQ; k++) begin
         cand = (cand == IW'(NUMREQ - 1)) ? '0 : cand + 1'b1;
         if (!win_found && req_valid[cand]) begin
            win       = cand;
            win_found = 1'b1;
         end
      end
   end

   // Ready is gated by Rst so nobody sees an accept that the reset discards.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && Rst && win_found)
         req_ready[win] = 1'b1;
   end

   mod_unit #(.W(DATAWIDTH)) u_mod (
      .a   (op_a),
      .b   (op_b),
      .rem (mod_rem),
      .dz  (mod_dz)
   );

   assign busy = (state != IDLE);

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state     <= IDLE;
         last      <= IW'(NUMREQ - 1);
         gnt       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         rsp_rem   <= '0;
         rsp_dz    <= 1'b0;
         rsp_valid <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  op_a  <= a_arr[win];
                  op_b  <= b_arr[win];
                  gnt   <= req_ready;
                  last  <= win;
                  state <= EXEC;
               end
            end
            EXEC: begin
               rsp_rem   <= mod_rem;
               rsp_dz    <= mod_dz;
               rsp_valid <= gnt;
               state     <= RESP;
            end
            RESP: begin
               // Only the granted requester's rsp_ready matters.
               if (|(rsp_ready & gnt)) begin
                  rsp_valid <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/mod_arbiter.md
# mod_arbiter

Round-robin arbiter and sequencer that shares one combinational MOD datapath unit among NUMREQ requesters. It accepts an operand pair from one requester at a time over a valid/ready handshake and drives the registered operands into a single internal MOD instance. It captures the remainder, with divide-by-zero protection, and returns it to the granted requester over a response handshake. It sits between the datapath's MOD consumers and the shared MOD unit.

## Interface
- DATAWIDTH, 32, operand/remainder width in bits
- NUMREQ, 4, number of requesters (legal 2..8)

- Clk  input  1  rising-edge clock
- Rst  input  1  reset; one clock; reset is synchronous and active-low
- req_valid  input  NUMREQ  bit i: requester i presents an operand pair
- req_ready  output  NUMREQ  bit i: requester i's pair is accepted this cycle (one-hot or zero)
- req_a  input  NUMREQ*DATAWIDTH  dividends; requester i at [i*DATAWIDTH +: DATAWIDTH]
- req_b  input  NUMREQ*DATAWIDTH  divisors; same packing
- rsp_valid  output  NUMREQ  bit i: response for requester i is valid (one-hot or zero)
- rsp_ready  input  NUMREQ  bit i: requester i consumes its response
- rsp_rem  output  DATAWIDTH  remainder, shared by all requesters, qualified by rsp_valid
- rsp_dz  output  1  divisor was zero, qualified by rsp_valid
- busy  output  1  high in any state other than IDLE

## Operation
- State machine with three states: IDLE, EXEC, RESP.
- Internal registers:
  - op_a, op_b: operands
  - gnt: one-hot index of the granted requester
  - last: index of the last granted requester
  - rsp_rem, rsp_dz
- IDLE:
  - Winner is the first requester with req_valid set, searching from (last+1) mod NUMREQ upward with wrap-around.
  - req_ready[winner] is asserted combinationally in the same cycle.
  - On that edge: op_a/op_b ← the winner's req_a/req_b, gnt ← winner, last ← winner, go to EXEC.
  - If no req_valid is set, stay in IDLE; req_ready = 0.
- EXEC:
  - The MOD instance (DATAWIDTH) sees op_a and op_b.
  - On the edge: rsp_rem ← (op_b == 0) ? op_a : op_a % op_b; rsp_dz ← (op_b == 0).
  - Go to RESP unconditionally.
- RESP:
  - rsp_valid = gnt.
  - rsp_rem/rsp_dz are held stable.
  - When rsp_ready[gnt] is high on the edge, go to IDLE.
  - rsp_ready bits of non-granted requesters are ignored.
- Arbitration rules:
  - Arbitration is re-evaluated every IDLE cycle.
  - A requester that drops req_valid before being granted is simply skipped; no grant is held or reserved.
  - req_ready is 0 in EXEC and RESP; no new request is accepted while a transaction is outstanding.
- Operands are sampled only on the handshake cycle. After that, req_a/req_b may change freely.
- Arithmetic:
  - Unsigned, full DATAWIDTH, no truncation.
  - Divide-by-zero never produces X: the result is rem = a with rsp_dz = 1.

## Timing
- Reset (Rst = 0 at an edge):
  - state = IDLE
  - last = NUMREQ-1, so requester 0 has top priority after reset
  - gnt = 0
  - rsp_valid = 0, req_ready = 0, busy = 0
  - rsp_rem = 0, rsp_dz = 0
- Latency: handshake at edge T, rsp_valid asserted from cycle T+1 to T+2 (after the EXEC edge), i.e. visible 2 cycles after acceptance.
- Minimum issue interval is 3 cycles when rsp_ready is held high: IDLE, EXEC, RESP.
- Back-to-back: after RESP completes at edge T, the next grant can handshake in IDLE at cycle T+1.
- Reset mid-operation (EXEC or RESP):
  - The transaction is dropped; no response is ever produced.
  - Priority restarts at requester 0.
- Simultaneous req_valid from all requesters with rsp_ready tied high: grants are issued strictly in rotating order, so no requester starves. Worst-case wait is (NUMREQ-1) transactions.
- Backpressure: rsp_valid and rsp_rem/rsp_dz stay constant for any number of cycles while rsp_ready[gnt] = 0.

## Test plan
- Single request, DATAWIDTH = 32: requester 1 presents a = 17, b = 5 → req_ready[1] in the same cycle; rsp_valid = 4'b0010 two cycles later; rsp_rem = 2, rsp_dz = 0.
- Divide-by-zero: a = 9, b = 0 → rsp_rem = 9, rsp_dz = 1, no X on any output.
- Fairness: all four req_valid held high from reset, with operands a = 100+i, b = 7 → grants in order 0,1,2,3,0; remainders 2,3,4,5,2.
- Rotation: last = 2, with requesters 0 and 3 requesting → 3 is granted first, then 0.
- Backpressure: rsp_ready low for 5 cycles in RESP → rsp_valid, rsp_rem, rsp_dz stable; req_ready stays 0 for all requesters despite pending req_valid; release → IDLE the next cycle.
- Reset mid-operation: assert Rst = 0 for one edge while in EXEC → no rsp_valid appears; busy = 0; with requesters 0 and 2 pending, requester 0 is granted first.
